// File: rtl/sma_level_detector.sv
// Debounced level detector with hysteresis thresholds for a moving-average sample stream.
// A level change needs HOLD_COUNT consecutive qualifying valid samples. Each completed change
// produces a one-entry event record {rising, sample index}. The record is held until the
// consumer accepts it. An event that arrives while the record is still waiting is dropped,
// and the sticky overflow flag is set.
module sma_level_detector #(
  parameter int unsigned DATA_INPUT_WIDTH = 16,
  parameter int unsigned HOLD_COUNT       = 4,
  parameter int unsigned INDEX_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_INPUT_WIDTH-1:0] in_data,
  input  logic                        in_data_valid,
  input  logic [DATA_INPUT_WIDTH-1:0] thresh_hi,
  input  logic [DATA_INPUT_WIDTH-1:0] thresh_lo,
  output logic                        level_high,
  output logic                        event_valid,
  input  logic                        event_ready,
  output logic                        event_rising,
  output logic [INDEX_WIDTH-1:0]      event_index,
  output logic                        overflow,
  input  logic                        clr_overflow
);

  typedef enum logic [1:0] {
    StLow      = 2'd0,
    StRisePend = 2'd1,
    StHigh     = 2'd2,
    StFallPend = 2'd3
  } state_e;

  // With HOLD_COUNT == 1, the first qualifying sample completes the transition directly.
  localparam bit         HoldIsOne = (HOLD_COUNT == 32'd1);
  // A pending count equal to this value means the current qualifying sample is the last one.
  localparam logic [7:0] HoldLast  = 8'(HOLD_COUNT - 1);

  state_e                 state_q, state_d;
  logic [7:0]             hold_cnt_q, hold_cnt_d;
  logic [INDEX_WIDTH-1:0] sample_index_q, sample_index_d;
  logic                   level_q, level_d;
  logic                   ev_valid_q, ev_valid_d;
  logic                   ev_rising_q, ev_rising_d;
  logic [INDEX_WIDTH-1:0] ev_index_q, ev_index_d;
  logic                   overflow_q, overflow_d;

  logic rise_hit;
  logic fall_hit;
  logic evt_gen;
  logic evt_rise;
  logic ovf_set;

  // Unsigned full-width threshold tests. An inverted threshold pair needs no special case.
  assign rise_hit = (in_data >= thresh_hi);
  assign fall_hit = (in_data <= thresh_lo);

  // Debounce FSM: advances only on valid samples, flags a transition-completing sample
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    evt_gen    = 1'b0;
    evt_rise   = 1'b0;
    if (in_data_valid) begin
      unique case (state_q)
        StLow: begin
          if (rise_hit) begin
            if (HoldIsOne) begin
              state_d  = StHigh;
              evt_gen  = 1'b1;
              evt_rise = 1'b1;
            end else begin
              state_d    = StRisePend;
              hold_cnt_d = 8'd1;
            end
          end
        end
        StRisePend: begin
          if (rise_hit) begin
            if (hold_cnt_q == HoldLast) begin
              state_d    = StHigh;
              hold_cnt_d = 8'd0;
              evt_gen    = 1'b1;
              evt_rise   = 1'b1;
            end else begin
              hold_cnt_d = hold_cnt_q + 8'd1;
            end
          end else begin
            state_d    = StLow;
            hold_cnt_d = 8'd0;
          end
        end
        StHigh: begin
          if (fall_hit) begin
            if (HoldIsOne) begin
              state_d = StLow;
              evt_gen = 1'b1;
            end else begin
              state_d    = StFallPend;
              hold_cnt_d = 8'd1;
            end
          end
        end
        StFallPend: begin
          if (fall_hit) begin
            if (hold_cnt_q == HoldLast) begin
              state_d    = StLow;
              hold_cnt_d = 8'd0;
              evt_gen    = 1'b1;
            end else begin
              hold_cnt_d = hold_cnt_q + 8'd1;
            end
          end else begin
            state_d    = StHigh;
            hold_cnt_d = 8'd0;
          end
        end
        default: begin
          state_d    = StLow;
          hold_cnt_d = 8'd0;
        end
      endcase
    end
  end

  // Sample index counts every valid sample and wraps naturally; level mirrors the next state
  always_comb begin
    sample_index_d = sample_index_q;
    if (in_data_valid) begin
      sample_index_d = sample_index_q + INDEX_WIDTH'(1);
    end
    level_d = (state_d == StHigh) || (state_d == StFallPend);
  end

  // Single-entry event register: load when empty or draining this cycle, otherwise drop
  always_comb begin
    ev_valid_d  = ev_valid_q;
    ev_rising_d = ev_rising_q;
    ev_index_d  = ev_index_q;
    ovf_set     = 1'b0;
    if (evt_gen) begin
      if (!ev_valid_q || event_ready) begin
        ev_valid_d  = 1'b1;
        ev_rising_d = evt_rise;
        // Index of the sample that completes the transition, not the one after it.
        ev_index_d  = sample_index_q;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (ev_valid_q && event_ready) begin
      ev_valid_d = 1'b0;
    end
    // If the flag is set and cleared in the same cycle, the set wins.
    overflow_d = ovf_set | (overflow_q & ~clr_overflow);
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StLow;
      hold_cnt_q     <= 8'd0;
      sample_index_q <= '0;
      level_q        <= 1'b0;
      ev_valid_q     <= 1'b0;
      ev_rising_q    <= 1'b0;
      ev_index_q     <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      sample_index_q <= sample_index_d;
      level_q        <= level_d;
      ev_valid_q     <= ev_valid_d;
      ev_rising_q    <= ev_rising_d;
      ev_index_q     <= ev_index_d;
      overflow_q     <= overflow_d;
    end
  end

  assign level_high   = level_q;
  assign event_valid  = ev_valid_q;
  assign event_rising = ev_rising_q;
  assign event_index  = ev_index_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_sma_level_detector.sv
// Bench for sma_level_detector. A behavioural model tracks the level and the run length of
// qualifying samples. Directed scenarios pin the outputs to hand-computed literal values.
// A randomized phase follows.
module tb_sma_level_detector;

  localparam int DW = 16;
  localparam int HC = 4;
  localparam int IW = 6;  // small index width so the random phase exercises wraparound

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_data_valid = 1'b0;
  logic [DW-1:0] thresh_hi = 16'd1000;
  logic [DW-1:0] thresh_lo = 16'd500;
  logic          level_high;
  logic          event_valid;
  logic          event_ready = 1'b1;
  logic          event_rising;
  logic [IW-1:0] event_index;
  logic          overflow;
  logic          clr_overflow = 1'b0;

  always #5 clk = ~clk;

  sma_level_detector #(
    .DATA_INPUT_WIDTH(DW),
    .HOLD_COUNT      (HC),
    .INDEX_WIDTH     (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_data_valid(in_data_valid),
    .thresh_hi    (thresh_hi),
    .thresh_lo    (thresh_lo),
    .level_high   (level_high),
    .event_valid  (event_valid),
    .event_ready  (event_ready),
    .event_rising (event_rising),
    .event_index  (event_index),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: level plus the number of consecutive samples pulling the other way
  bit model_live = 1'b0;
  bit m_level;
  int m_run;
  int m_idx;
  bit m_ev_valid;
  bit m_ev_rising;
  int m_ev_index;
  bit m_ovf;
  bit m_gen;
  bit m_qual;
  bit m_set;
  int m_samp;

  always @(posedge clk) begin
    if (rst) begin
      model_live  = 1'b1;
      m_level     = 1'b0;
      m_run       = 0;
      m_idx       = 0;
      m_ev_valid  = 1'b0;
      m_ev_rising = 1'b0;
      m_ev_index  = 0;
      m_ovf       = 1'b0;
    end else if (model_live) begin
      m_gen  = 1'b0;
      m_samp = m_idx;
      if (in_data_valid) begin
        m_qual = m_level ? (in_data <= thresh_lo) : (in_data >= thresh_hi);
        if (m_qual) begin
          m_run = m_run + 1;
          if (m_run == HC) begin
            m_level = !m_level;
            m_run   = 0;
            m_gen   = 1'b1;
          end
        end else begin
          m_run = 0;
        end
        m_idx = (m_idx + 1) % (1 << IW);
      end
      m_set = m_gen && m_ev_valid && !event_ready;
      if (m_gen && !m_set) begin
        m_ev_valid  = 1'b1;
        m_ev_rising = m_level;
        m_ev_index  = m_samp;
      end else if (!m_gen && m_ev_valid && event_ready) begin
        m_ev_valid = 1'b0;
      end
      m_ovf = m_set || (m_ovf && !clr_overflow);
    end
  end

  // Compare every cycle once the model has been through a reset
  always @(negedge clk) begin
    if (model_live) begin
      check("level_high", {31'd0, level_high}, {31'd0, m_level});
      check("event_valid", {31'd0, event_valid}, {31'd0, m_ev_valid});
      check("event_rising", {31'd0, event_rising}, {31'd0, m_ev_rising});
      check("event_index", {26'd0, event_index}, m_ev_index);
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  task automatic drive(input int d);
    @(negedge clk);
    in_data       = DW'(d);
    in_data_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_data_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    in_data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lit_event(input string name, input bit v, input bit r, input int idx);
    check({name, ".valid"}, {31'd0, event_valid}, {31'd0, v});
    check({name, ".rising"}, {31'd0, event_rising}, {31'd0, r});
    check({name, ".index"}, {26'd0, event_index}, idx);
  endtask

  bit mode_hi;

  initial begin
    do_reset();
    check("reset.level", {31'd0, level_high}, 32'd0);
    lit_event("reset.ev", 1'b0, 1'b0, 0);
    check("reset.ovf", {31'd0, overflow}, 32'd0);

    // Basic rise: level changes one cycle after sample index 4
    event_ready = 1'b1;
    drive(0);
    repeat (4) drive(1200);
    check("rise.before", {31'd0, level_high}, 32'd0);
    idle(1);
    check("rise.level", {31'd0, level_high}, 32'd1);
    lit_event("rise.ev", 1'b1, 1'b1, 4);

    // A non-qualifying sample restarts the hold count
    do_reset();
    drive(1200); drive(1200); drive(900);
    repeat (4) drive(1200);
    idle(1);
    check("restart.level", {31'd0, level_high}, 32'd1);
    lit_event("restart.ev", 1'b1, 1'b1, 6);

    // Fall with idle gaps between valid samples
    for (int k = 0; k < 3; k++) begin
      drive(400);
      idle(3);
    end
    check("gap.still_high", {31'd0, level_high}, 32'd1);
    check("gap.no_event", {31'd0, event_valid}, 32'd0);
    drive(400);
    idle(1);
    check("gap.level", {31'd0, level_high}, 32'd0);
    lit_event("gap.ev", 1'b1, 1'b0, 10);

    // Back-pressure: the first event is held and the second is dropped
    do_reset();
    event_ready = 1'b0;
    repeat (4) drive(1200);
    idle(1);
    lit_event("bp.first", 1'b1, 1'b1, 3);
    repeat (4) drive(400);
    idle(1);
    check("bp.level", {31'd0, level_high}, 32'd0);
    lit_event("bp.held", 1'b1, 1'b1, 3);
    check("bp.ovf", {31'd0, overflow}, 32'd1);
    @(negedge clk); clr_overflow = 1'b1;
    @(negedge clk); clr_overflow = 1'b0;
    check("bp.clr", {31'd0, overflow}, 32'd0);

    // A new event arrives in the same cycle as a transfer
    repeat (3) drive(1200);
    drive(1200);
    event_ready = 1'b1;
    idle(1);
    lit_event("xfer.ev", 1'b1, 1'b1, 11);
    check("xfer.ovf", {31'd0, overflow}, 32'd0);

    // Reset during a pending rise with an event outstanding
    do_reset();
    event_ready = 1'b0;
    repeat (4) drive(1200);
    repeat (4) drive(400);
    repeat (3) drive(1200);
    @(negedge clk);
    rst           = 1'b1;
    in_data_valid = 1'b1;
    event_ready   = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    in_data_valid = 1'b0;
    check("rstmid.level", {31'd0, level_high}, 32'd0);
    lit_event("rstmid.ev", 1'b0, 1'b0, 0);
    check("rstmid.ovf", {31'd0, overflow}, 32'd0);
    repeat (4) drive(1200);
    idle(1);
    lit_event("rstmid.rise", 1'b1, 1'b1, 3);

    // Randomized phase: runs of samples biased toward each side, with occasional inverted thresholds
    mode_hi = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (i % 300 == 0) begin
        thresh_hi = DW'($urandom_range(200, 1800));
        thresh_lo = DW'($urandom_range(100, 1700));
      end
      if ($urandom_range(0, 9) == 0) mode_hi = !mode_hi;
      rst           = ($urandom_range(0, 799) == 0);
      in_data_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 2) in_data = DW'($urandom_range(0, 2047));
      else if (mode_hi) in_data = DW'($urandom_range(int'(thresh_hi), 2047));
      else in_data = DW'($urandom_range(0, int'(thresh_lo)));
      event_ready  = ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    rst           = 1'b0;
    in_data_valid = 1'b0;
    clr_overflow  = 1'b0;
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sma_level_detector.md
SMA_LEVEL_DETECTOR -- requirements
Module: sma_level_detector

Interface
REQ-001 SHALL have parameter DATA_INPUT_WIDTH, default 16: width of the filtered sample from the upstream moving-average stage.
REQ-002 SHALL have parameter HOLD_COUNT, default 4, legal range 1..255: number of consecutive qualifying samples required to change level.
REQ-003 SHALL have parameter INDEX_WIDTH, default 16: width of the sample index counter.
REQ-004 SHALL have ports:
- clk  input  1  sole clock, all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  DATA_INPUT_WIDTH  unsigned filtered sample (from sma out_data).
- in_data_valid  input  1  sample qualifier (from sma out_data_valid).
- thresh_hi  input  DATA_INPUT_WIDTH  unsigned rise threshold, sampled every valid cycle.
- thresh_lo  input  DATA_INPUT_WIDTH  unsigned fall threshold, sampled every valid cycle.
- level_high  output  1  current debounced level.
- event_valid  output  1  event record available.
- event_ready  input  1  consumer accepts event.
- event_rising  output  1  1 = LOW->HIGH event, 0 = HIGH->LOW.
- event_index  output  INDEX_WIDTH  sample index of the transition-completing sample.
- overflow  output  1  sticky: an event was dropped.
- clr_overflow  input  1  clears overflow.

Function
REQ-005 SHALL implement FSM states LOW, RISE_PEND, HIGH, FALL_PEND; FSM and counters advance only on cycles with in_data_valid=1.
REQ-006 Qualifying-rise sample: in_data >= thresh_hi. Qualifying-fall sample: in_data <= thresh_lo. Comparisons unsigned, full width.
REQ-007 LOW: rise sample -> HIGH if HOLD_COUNT=1, else RISE_PEND with hold_cnt=1; otherwise stay LOW.
REQ-008 RISE_PEND: rise sample -> hold_cnt+1; reaching HOLD_COUNT -> HIGH, hold_cnt=0; non-rise sample -> LOW, hold_cnt=0.
REQ-009 HIGH and FALL_PEND SHALL mirror REQ-007/008 using fall samples, returning to HIGH on a non-fall sample.
REQ-010 level_high SHALL be 1 in HIGH and FALL_PEND, 0 in LOW and RISE_PEND, registered.
REQ-011 sample_index SHALL increment by 1 on every in_data_valid cycle, wrapping at 2^INDEX_WIDTH-1 -> 0; the first sample after reset has index 0.
REQ-012 On each LOW/RISE_PEND->HIGH or HIGH/FALL_PEND->LOW transition the block SHALL generate an event {rising, index of that sample}, presented on event_* the next cycle (latency 1), concurrently with the level_high update.
REQ-013 Event output SHALL be a single-entry register; an event transfers when event_valid=1 and event_ready=1; event_rising/event_index SHALL hold stable while event_valid=1 and event_ready=0.
REQ-014 New event while the register is full and event_ready=0: new event dropped, stored event kept, overflow set to 1 next cycle.
REQ-015 New event in the same cycle as a transfer: new event loaded, event_valid stays 1, no overflow.
REQ-016 overflow SHALL clear on clr_overflow=1; simultaneous set and clear SHALL leave overflow=1.
REQ-017 If thresh_hi <= thresh_lo, REQ-006 rules SHALL still apply unchanged; no error flag.

Reset
REQ-018 rst=1 at a clock edge SHALL force state LOW, hold_cnt=0, sample_index=0, level_high=0, event_valid=0, event_rising=0, event_index=0, overflow=0, regardless of in_data_valid, event_ready or clr_overflow.
REQ-019 Reset asserted mid-debounce or with a pending event SHALL discard both; the first valid sample after rst deasserts is index 0 in LOW.

Verification
REQ-020 HOLD_COUNT=4, hi=1000, lo=500, event_ready=1; samples 0,1200,1200,1200,1200 -> level_high=1 one cycle after sample index 4; event rising=1, index=4.
REQ-021 Same config; samples 1200,1200,900,1200,1200,1200,1200 -> no event at index 2, rise event index=6.
REQ-022 From HIGH: samples 400x4 with valid gaps of 3 idle cycles between -> fall event only after the 4th valid sample; idle cycles change nothing.
REQ-023 event_ready=0; force rise then fall -> first event held stable, overflow=1, second dropped; clr_overflow=1 -> overflow=0.
REQ-024 Event pending and event_ready=1 in the same cycle a new event is generated -> new event loaded, event_valid stays 1, overflow stays 0.
REQ-025 rst=1 during RISE_PEND (hold_cnt=3) with event pending -> all outputs 0 next cycle; subsequent 1200x4 yields rise event index=3.
